// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer
//
// Drives the 2-bit frame select {SEL0,SEL1} of the four-frame 7x5 matrix
// multiplexer. The sequencer steps through the frames enabled in MASK, showing
// each for DWELL clock cycles while RUN is high. It skips disabled frames,
// accepts a one-cycle manual STEP, and pulses FRAME_TICK whenever a frame starts.
//
// Optional feature: define MATRIX_FRAME_SEQUENCER_BLANK_EN to insert a blanking
// interval of BLANK_CYCLES cycles on every advance. When the macro is undefined,
// BLANK is tied low and an advance goes straight to the next frame.
//
// Parameters:
//   DWELL         frame display time in CLK cycles (>= 2)
//   BLANK_CYCLES  blanking interval in CLK cycles (>= 1), blanking builds only
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   synchronous reset, active-high
//   RUN         in   1 = automatic advance, 0 = dwell counter frozen
//   STEP        in   one-cycle manual advance request
//   MASK[3:0]   in   frame enables, bit i = frame i
//   SEL0        out  frame index MSB
//   SEL1        out  frame index LSB
//   BLANK       out  display must be blanked
//   FRAME_TICK  out  one-cycle pulse at each frame start
//   ACTIVE      out  a frame is being shown (SHOW or BLANK)

module matrix_frame_sequencer #(
    parameter int unsigned DWELL        = 25000000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic       STEP,
    input  logic [3:0] MASK,
    output logic       SEL0,
    output logic       SEL1,
    output logic       BLANK,
    output logic       FRAME_TICK,
    output logic       ACTIVE
);

    // Reject parameter values that would break the counter compares.
    if (DWELL < 2) begin : g_dwell_chk
        $error("DWELL must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_blank_chk
        $error("BLANK_CYCLES must be at least 1");
    end

    localparam int unsigned DW = $clog2(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShow  = 2'd1;
`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
    localparam logic [1:0] StBlank = 2'd2;

    // A one-cycle interval still needs a one-bit counter.
    localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
`endif

    // ------------------------------------------------------------------
    // Frame search helpers
    // ------------------------------------------------------------------

    // First enabled frame after f in rotating order f+1, f+2, f+3, f.
    // If f is the only enabled frame, the search wraps back to f itself.
    function automatic logic [1:0] next_frame(input logic [1:0] f, input logic [3:0] m);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = f;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = f + 2'(i);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Lowest enabled frame. Only used when m != 0.
    function automatic logic [1:0] first_frame(input logic [3:0] m);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                res = 2'(i);
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic [1:0]    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          active_q, active_d;
    logic          advance;
`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blank_q, blank_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        advance  = 1'b0;
`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
        bcnt_d   = bcnt_q;
`endif

        case (state_q)
            StIdle: begin
                if (MASK != 4'b0000) begin
                    state_d = StShow;
                    sel_d   = first_frame(MASK);
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                end
            end

            StShow: begin
                // Expiry and STEP together still give one advance. A frame that
                // was disabled under us is left immediately.
                advance = STEP || !MASK[sel_q] || (RUN && (cnt_q == DWELL_LAST));
                if (advance) begin
                    sel_d = next_frame(sel_q, MASK);
                    cnt_d = '0;
`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
                    state_d = StBlank;
                    bcnt_d  = '0;
`else
                    tick_d  = 1'b1;
`endif
                end else if (RUN) begin
                    cnt_d = cnt_q + DW'(1);
                end
            end

`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
            StBlank: begin
                // STEP is ignored here. MASK is re-checked once SHOW is entered.
                if (bcnt_q == BLANK_LAST) begin
                    state_d = StShow;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase

        // An empty mask overrides everything. SEL keeps its last value.
        if (MASK == 4'b0000) begin
            state_d = StIdle;
            sel_d   = sel_q;
            cnt_d   = '0;
            tick_d  = 1'b0;
`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
            bcnt_d  = '0;
`endif
        end

        active_d = (state_d != StIdle);
`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
        blank_d  = (state_d == StBlank);
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            active_q <= active_d;
        end
    end

`ifdef MATRIX_FRAME_SEQUENCER_BLANK_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcnt_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blank_q <= blank_d;
        end
    end

    assign BLANK = blank_q;
`else
    assign BLANK = 1'b0;
`endif

    assign SEL0       = sel_q[1];
    assign SEL1       = sel_q[0];
    assign FRAME_TICK = tick_q;
    assign ACTIVE     = active_q;

endmodule
